// File: rtl/cordic_core.sv
// Iterative rotation-mode CORDIC: 2**AW micro-rotations fed by an external
// registered-read arctangent ROM, one iteration per clock, no gain correction.
module cordic_core #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          bgn,
   input  logic [DW-1:0] x_in,
   input  logic [DW-1:0] y_in,
   input  logic [DW-1:0] z_in,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic [DW-1:0] x_out,
   output logic [DW-1:0] y_out,
   output logic [DW-1:0] z_out,
   output logic          busy,
   output logic          fin
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [AW-1:0] k_q, k_d;
   logic signed [DW-1:0] x_q, x_d;
   logic signed [DW-1:0] y_q, y_d;
   logic signed [DW-1:0] z_q, z_d;

   logic [DW-1:0] x_out_q, x_out_d;
   logic [DW-1:0] y_out_q, y_out_d;
   logic [DW-1:0] z_out_q, z_out_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic          busy_q, busy_d;
   logic          fin_q, fin_d;

   logic signed [DW-1:0] x_sh_s, y_sh_s;
   logic signed [DW-1:0] x_step_s, y_step_s, z_step_s;
   logic                 z_neg_s;

   // Signed accumulate in either direction; wraps modulo 2**DW.
   function automatic logic [DW-1:0] add_dir(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic          sub);
      logic [DW-1:0] r;
      if (sub) begin
         r = a - b;
      end else begin
         r = a + b;
      end
      return r;
   endfunction

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         x_out_q    <= '0;
         y_out_q    <= '0;
         z_out_q    <= '0;
         rom_addr_q <= '0;
         busy_q     <= 1'b0;
         fin_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         x_q        <= x_d;
         y_q        <= y_d;
         z_q        <= z_d;
         x_out_q    <= x_out_d;
         y_out_q    <= y_out_d;
         z_out_q    <= z_out_d;
         rom_addr_q <= rom_addr_d;
         busy_q     <= busy_d;
         fin_q      <= fin_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bgn) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: state_d = S_ITER;
         S_ITER: begin
            if (k_q == {AW{1'b1}}) begin
               state_d = S_DONE;
            end else begin
               state_d = S_ITER;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // One micro-rotation; direction follows the sign of the residual angle
   always_comb begin
      z_neg_s  = z_q[DW-1];
      x_sh_s   = x_q >>> k_q;
      y_sh_s   = y_q >>> k_q;
      x_step_s = add_dir(x_q, y_sh_s, ~z_neg_s);
      y_step_s = add_dir(y_q, x_sh_s, z_neg_s);
      z_step_s = add_dir(z_q, rom_data, ~z_neg_s);
   end

   // Working vector and iteration counter
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      k_d = k_q;
      case (state_q)
         S_IDLE: begin
            if (bgn) begin
               x_d = x_in;
               y_d = y_in;
               z_d = z_in;
               k_d = '0;
            end else begin
               k_d = k_q;
            end
         end
         S_ITER: begin
            x_d = x_step_s;
            y_d = y_step_s;
            z_d = z_step_s;
            k_d = k_q + {{(AW-1){1'b0}}, 1'b1};
         end
         default: begin
            k_d = k_q;
         end
      endcase
   end

   // Registered outputs; rom_addr runs one entry ahead to hide the ROM latency
   always_comb begin
      busy_d  = (state_d == S_LOAD) || (state_d == S_ITER);
      fin_d   = (state_d == S_DONE);
      x_out_d = x_out_q;
      y_out_d = y_out_q;
      z_out_d = z_out_q;
      if (state_d == S_ITER) begin
         rom_addr_d = k_d + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         rom_addr_d = '0;
      end
      if ((state_q == S_ITER) && (state_d == S_DONE)) begin
         x_out_d = x_d;
         y_out_d = y_d;
         z_out_d = z_d;
      end else begin
         x_out_d = x_out_q;
      end
   end

   assign rom_addr = rom_addr_q;
   assign x_out    = x_out_q;
   assign y_out    = y_out_q;
   assign z_out    = z_out_q;
   assign busy     = busy_q;
   assign fin      = fin_q;

endmodule
